// File: rtl/soin_bp_pkg.sv
// Shared constants and types for the branch-predictor counter-table update path.
package soin_bp_pkg;

  // Counter table geometry and sweep value (weakly not-taken).
  localparam int             IDX_W    = 12;
  localparam int             CTR_W    = 2;
  localparam logic [CTR_W-1:0] INIT_VAL = 2'b01;

  // Fetch-time metadata layout carried alongside a resolved branch.
  localparam int BP_META_WIDTH = 18;
  localparam int META_IDX_LSB  = 0;
  localparam int META_CTR_LSB  = 12;
  localparam int META_RAS_LSB  = 14;
  localparam int META_RAS_W    = 4;

  // Controller modes: table sweep, then normal update draining.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } upd_state_e;

endpackage

// File: rtl/soin_bp_upd_fifo.sv
// Small synchronous FIFO holding pending counter-table writes.
// Same-cycle push and pop is allowed even when full; rd_data shows the head entry.
module soin_bp_upd_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full queue is only taken when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; clearing them discards all entries.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/soin_bpredictor_update_ctrl.sv
// Counter-table update controller: sweeps the table to INIT_VAL, then drains
// resolved-branch updates (queued with their new counter value) onto the write port.
module soin_bpredictor_update_ctrl #(
  parameter int               IDX_W      = soin_bp_pkg::IDX_W,
  parameter int               CTR_W      = soin_bp_pkg::CTR_W,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [CTR_W-1:0] INIT_VAL   = soin_bp_pkg::INIT_VAL
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  ctrl_flush,
  input  logic                                  execute_bpredictor_update,
  input  logic                                  execute_bpredictor_dir,
  input  logic [soin_bp_pkg::BP_META_WIDTH-1:0] execute_bpredictor_meta,
  output logic [IDX_W-1:0]                      up_index,
  output logic [CTR_W-1:0]                      up_data,
  output logic                                  up_wen,
  output logic                                  ghr_shift,
  output logic                                  ghr_dir,
  output logic                                  init_busy,
  output logic [7:0]                            drop_count
);

  localparam int               ENT_W   = IDX_W + CTR_W + 1;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  soin_bp_pkg::upd_state_e state_q, state_d;
  logic [IDX_W-1:0] sweep_addr_q, sweep_addr_d;
  logic             sweep_done_q, sweep_done_d;
  logic [IDX_W-1:0] up_index_q, up_index_d;
  logic [CTR_W-1:0] up_data_q, up_data_d;
  logic             up_wen_q, up_wen_d;
  logic             ghr_shift_q, ghr_shift_d;
  logic             ghr_dir_q, ghr_dir_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic [IDX_W-1:0] upd_index;
  logic [CTR_W-1:0] upd_old, upd_new;
  logic             fifo_srst, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0] fifo_wr_data, fifo_rd_data;
  logic             meta_unused;

  assign upd_index   = execute_bpredictor_meta[soin_bp_pkg::META_IDX_LSB +: IDX_W];
  assign upd_old     = execute_bpredictor_meta[soin_bp_pkg::META_CTR_LSB +: CTR_W];
  // The RAS index rides along in the metadata but belongs to another block.
  assign meta_unused = ^execute_bpredictor_meta[soin_bp_pkg::META_RAS_LSB +: soin_bp_pkg::META_RAS_W];

  // Saturating counter step, done before queuing so the drain path is a plain copy.
  always_comb begin
    upd_new = upd_old;
    if (execute_bpredictor_dir) begin
      if (upd_old != CTR_MAX) upd_new = upd_old + CTR_ONE;
    end else begin
      if (upd_old != '0) upd_new = upd_old - CTR_ONE;
    end
  end

  // A flush discards the coinciding update outright and freezes draining for that cycle.
  assign fifo_push    = execute_bpredictor_update & ~ctrl_flush;
  assign fifo_pop     = (state_q == soin_bp_pkg::ST_RUN) & ~fifo_empty & ~ctrl_flush;
  assign fifo_srst    = ~reset | ctrl_flush;
  assign fifo_wr_data = {upd_index, upd_new, execute_bpredictor_dir};

  soin_bp_upd_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (fifo_srst),
    .push    (fifo_push),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state: sweep in INIT, drain the queue in RUN, count overflow drops.
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    sweep_done_d = sweep_done_q;
    up_index_d   = up_index_q;
    up_data_d    = up_data_q;
    up_wen_d     = 1'b0;
    ghr_shift_d  = 1'b0;
    ghr_dir_d    = 1'b0;
    drop_count_d = drop_count_q;

    if (fifo_push && fifo_full && !fifo_pop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end

    if (ctrl_flush) begin
      state_d      = soin_bp_pkg::ST_INIT;
      sweep_addr_d = '0;
      sweep_done_d = 1'b0;
    end else begin
      case (state_q)
        soin_bp_pkg::ST_INIT: begin
          // The cycle after the last sweep write is spent switching to RUN,
          // so init_busy stays high for as long as sweep writes are visible.
          if (sweep_done_q) begin
            state_d = soin_bp_pkg::ST_RUN;
          end else begin
            up_wen_d     = 1'b1;
            up_index_d   = sweep_addr_q;
            up_data_d    = INIT_VAL;
            sweep_addr_d = sweep_addr_q + IDX_ONE;
            if (sweep_addr_q == '1) sweep_done_d = 1'b1;
          end
        end
        soin_bp_pkg::ST_RUN: begin
          if (fifo_pop) begin
            up_wen_d    = 1'b1;
            ghr_shift_d = 1'b1;
            {up_index_d, up_data_d, ghr_dir_d} = fifo_rd_data;
          end
        end
        default: state_d = soin_bp_pkg::ST_INIT;
      endcase
    end
  end

  // State and registered write-port/GHR outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= soin_bp_pkg::ST_INIT;
      sweep_addr_q <= '0;
      sweep_done_q <= 1'b0;
      up_index_q   <= '0;
      up_data_q    <= '0;
      up_wen_q     <= 1'b0;
      ghr_shift_q  <= 1'b0;
      ghr_dir_q    <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      sweep_done_q <= sweep_done_d;
      up_index_q   <= up_index_d;
      up_data_q    <= up_data_d;
      up_wen_q     <= up_wen_d;
      ghr_shift_q  <= ghr_shift_d;
      ghr_dir_q    <= ghr_dir_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign up_index   = up_index_q;
  assign up_data    = up_data_q;
  assign up_wen     = up_wen_q;
  assign ghr_shift  = ghr_shift_q;
  assign ghr_dir    = ghr_dir_q;
  assign drop_count = drop_count_q;
  assign init_busy  = (state_q == soin_bp_pkg::ST_INIT);

endmodule

// File: tb/tb_soin_bpredictor_update_ctrl.sv
// Directed bench for the counter-table update controller.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
`timescale 1ns/1ps
module tb_soin_bpredictor_update_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_flush = 1'b0;
  logic        execute_bpredictor_update = 1'b0;
  logic        execute_bpredictor_dir = 1'b0;
  logic [17:0] execute_bpredictor_meta = '0;
  logic [11:0] up_index;
  logic [1:0]  up_data;
  logic        up_wen;
  logic        ghr_shift;
  logic        ghr_dir;
  logic        init_busy;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  soin_bpredictor_update_ctrl dut (
    .clk                       (clk),
    .reset                     (reset),
    .ctrl_flush                (ctrl_flush),
    .execute_bpredictor_update (execute_bpredictor_update),
    .execute_bpredictor_dir    (execute_bpredictor_dir),
    .execute_bpredictor_meta   (execute_bpredictor_meta),
    .up_index                  (up_index),
    .up_data                   (up_data),
    .up_wen                    (up_wen),
    .ghr_shift                 (ghr_shift),
    .ghr_dir                   (ghr_dir),
    .init_busy                 (init_busy),
    .drop_count                (drop_count)
  );

  always #5 clk = ~clk;

  // Single-update vectors: index, old counter, direction, expected new counter.
  logic [11:0] v_idx [6] = '{12'h123, 12'h000, 12'hFFF, 12'h456, 12'h7A5, 12'h001};
  logic [1:0]  v_old [6] = '{2'b11,   2'b00,   2'b01,   2'b10,   2'b00,   2'b11};
  logic        v_dir [6] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
  logic [1:0]  v_exp [6] = '{2'b11,   2'b00,   2'b10,   2'b01,   2'b01,   2'b10};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [11:0] idx, input logic [1:0] old, input logic d);
    execute_bpredictor_update = 1'b1;
    execute_bpredictor_dir    = d;
    execute_bpredictor_meta   = {4'hA, old, idx};
  endtask

  task automatic clr_upd();
    execute_bpredictor_update = 1'b0;
    execute_bpredictor_dir    = 1'b0;
  endtask

  // Step until the sweep finishes, bounded; GHR must stay quiet throughout.
  task automatic wait_run(input string name);
    int n = 0;
    int bad = 0;
    while (init_busy === 1'b1 && n < 5000) begin
      if (ghr_shift !== 1'b0) bad++;
      step();
      n++;
    end
    checks++;
    if (init_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: init_busy=%b after %0d cycles, required 0", name, init_busy, n);
    end
    checks++;
    if (bad != 0 || ghr_shift !== 1'b0) begin
      errors++;
      $display("FAIL %s_ghr_in_init: %0d cycles with ghr_shift=1, required 0", name, bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (up_wen !== 1'b0 || ghr_shift !== 1'b0 || ghr_dir !== 1'b0 || up_index !== 12'h000 || up_data !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: wen=%b ghr=%b dir=%b idx=%h data=%b, required all 0", up_wen, ghr_shift, ghr_dir, up_index, up_data);
    end
    checks++;
    if (init_busy !== 1'b1 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: init_busy=%b drop_count=%0d, required 1 and 0", init_busy, drop_count);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_sweep();
    int bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if (up_wen !== 1'b1 || up_index !== 12'(i) || up_data !== 2'b01 || ghr_shift !== 1'b0 || init_busy !== 1'b1) begin
        if (bad == 0)
          $display("FAIL sweep_write: step %0d got wen=%b idx=%h data=%b ghr=%b busy=%b, required wen=1 idx=%h data=01 ghr=0 busy=1",
                   i, up_wen, up_index, up_data, ghr_shift, init_busy, 12'(i));
        bad++;
      end
      step();
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (init_busy !== 1'b0 || up_wen !== 1'b0) begin
      errors++;
      $display("FAIL sweep_end: init_busy=%b wen=%b, required 0 and 0", init_busy, up_wen);
    end
  endtask

  task automatic test_single_updates();
    for (int i = 0; i < 6; i++) begin
      set_upd(v_idx[i], v_old[i], v_dir[i]);
      step();
      clr_upd();
      checks++;
      if (up_wen !== 1'b0) begin
        errors++;
        $display("FAIL single_early_%0d: wen=%b, required 0", i, up_wen);
      end
      step();
      checks++;
      if (up_wen !== 1'b1 || up_index !== v_idx[i] || up_data !== v_exp[i] || ghr_shift !== 1'b1 || ghr_dir !== v_dir[i]) begin
        errors++;
        $display("FAIL single_write_%0d: wen=%b idx=%h data=%b ghr=%b dir=%b, required 1 %h %b 1 %b",
                 i, up_wen, up_index, up_data, ghr_shift, ghr_dir, v_idx[i], v_exp[i], v_dir[i]);
      end
      step();
      checks++;
      if (up_wen !== 1'b0 || ghr_shift !== 1'b0) begin
        errors++;
        $display("FAIL single_pulse_%0d: wen=%b ghr=%b, required 0 0", i, up_wen, ghr_shift);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Entries: idx 0x010+k, old 01, dir alternating 0/1/0 -> new 00/10/00.
    logic [1:0] exp_data [3] = '{2'b00, 2'b10, 2'b00};
    logic       exp_dir  [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      set_upd(12'h010 + 12'(k), 2'b01, exp_dir[k]);
      step();
      if (k > 0) begin
        checks++;
        if (up_wen !== 1'b1 || up_index !== 12'h010 + 12'(k - 1) || up_data !== exp_data[k-1] || ghr_dir !== exp_dir[k-1]) begin
          errors++;
          $display("FAIL b2b_write_%0d: wen=%b idx=%h data=%b dir=%b, required 1 %h %b %b",
                   k - 1, up_wen, up_index, up_data, ghr_dir, 12'h010 + 12'(k - 1), exp_data[k-1], exp_dir[k-1]);
        end
      end
    end
    clr_upd();
    step();
    checks++;
    if (up_wen !== 1'b1 || up_index !== 12'h012 || up_data !== 2'b00 || ghr_dir !== 1'b0) begin
      errors++;
      $display("FAIL b2b_write_2: wen=%b idx=%h data=%b dir=%b, required 1 012 00 0", up_wen, up_index, up_data, ghr_dir);
    end
    step();
    checks++;
    if (up_wen !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL b2b_tail: wen=%b drop_count=%0d, required 0 and 0", up_wen, drop_count);
    end
  endtask

  task automatic test_init_overflow();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    checks++;
    if (up_wen !== 1'b1 || up_index !== 12'h000 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sweep_start: wen=%b idx=%h busy=%b, required 1 000 1", up_wen, up_index, init_busy);
    end
    // Six updates while sweeping: idx 0x100..0x105, old 10, dir 1 -> new 11.
    for (int k = 0; k < 6; k++) begin
      set_upd(12'h100 + 12'(k), 2'b10, 1'b1);
      step();
    end
    clr_upd();
    step();
    checks++;
    if (drop_count !== 8'd2) begin
      errors++;
      $display("FAIL ovf_drop_count: got %0d, required 2", drop_count);
    end
    wait_run("ovf");
    checks++;
    if (up_wen !== 1'b0) begin
      errors++;
      $display("FAIL ovf_run_gap: wen=%b, required 0", up_wen);
    end
    // Queue is full and its head leaves this cycle: this push must be kept.
    set_upd(12'h0AA, 2'b01, 1'b0);
    step();
    clr_upd();
    for (int j = 0; j < 5; j++) begin
      logic [11:0] ei;
      logic [1:0]  ed;
      logic        edir;
      ei   = (j < 4) ? 12'h100 + 12'(j) : 12'h0AA;
      ed   = (j < 4) ? 2'b11 : 2'b00;
      edir = (j < 4);
      checks++;
      if (up_wen !== 1'b1 || up_index !== ei || up_data !== ed || ghr_shift !== 1'b1 || ghr_dir !== edir) begin
        errors++;
        $display("FAIL ovf_drain_%0d: wen=%b idx=%h data=%b ghr=%b dir=%b, required 1 %h %b 1 %b",
                 j, up_wen, up_index, up_data, ghr_shift, ghr_dir, ei, ed, edir);
      end
      step();
    end
    checks++;
    if (up_wen !== 1'b0 || drop_count !== 8'd2) begin
      errors++;
      $display("FAIL ovf_full_push: wen=%b drop_count=%0d, required 0 and 2", up_wen, drop_count);
    end
  endtask

  task automatic test_flush();
    int n = 0;
    int stray = 0;
    ctrl_flush = 1'b1;
    step();
    ctrl_flush = 1'b0;
    checks++;
    if (init_busy !== 1'b1 || up_wen !== 1'b0) begin
      errors++;
      $display("FAIL flush_run_enter: busy=%b wen=%b, required 1 0", init_busy, up_wen);
    end
    step();
    checks++;
    if (up_wen !== 1'b1 || up_index !== 12'h000) begin
      errors++;
      $display("FAIL flush_run_sweep0: wen=%b idx=%h, required 1 000", up_wen, up_index);
    end
    set_upd(12'h3C3, 2'b01, 1'b1);
    step();
    set_upd(12'h3C4, 2'b01, 1'b1);
    step();
    clr_upd();
    while (!(up_wen === 1'b1 && up_index === 12'h800) && n < 5000) begin
      step();
      n++;
    end
    checks++;
    if (up_index !== 12'h800) begin
      errors++;
      $display("FAIL flush_reach_800: idx=%h after %0d cycles, required 800", up_index, n);
    end
    // Flush at sweep address 0x800 with an update arriving in the same cycle.
    ctrl_flush = 1'b1;
    set_upd(12'h555, 2'b00, 1'b1);
    step();
    ctrl_flush = 1'b0;
    clr_upd();
    checks++;
    if (init_busy !== 1'b1 || up_wen !== 1'b0 || drop_count !== 8'd2) begin
      errors++;
      $display("FAIL flush_mid_sweep: busy=%b wen=%b drop_count=%0d, required 1 0 2", init_busy, up_wen, drop_count);
    end
    step();
    checks++;
    if (up_wen !== 1'b1 || up_index !== 12'h000 || up_data !== 2'b01) begin
      errors++;
      $display("FAIL flush_restart: wen=%b idx=%h data=%b, required 1 000 01", up_wen, up_index, up_data);
    end
    wait_run("flush");
    for (int c = 0; c < 8; c++) begin
      if (up_wen !== 1'b0) stray++;
      step();
    end
    checks++;
    if (stray != 0 || drop_count !== 8'd2) begin
      errors++;
      $display("FAIL flush_no_stale: %0d stray writes, drop_count=%0d, required 0 and 2", stray, drop_count);
    end
  endtask

  task automatic test_reset_mid_run();
    set_upd(12'h777, 2'b01, 1'b1);
    step();
    clr_upd();
    reset = 1'b0;
    step();
    checks++;
    if (up_wen !== 1'b0 || ghr_shift !== 1'b0 || up_index !== 12'h000 || up_data !== 2'b00 || init_busy !== 1'b1 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_run_state: wen=%b ghr=%b idx=%h data=%b busy=%b drop=%0d, required 0 0 000 00 1 0",
               up_wen, ghr_shift, up_index, up_data, init_busy, drop_count);
    end
    reset = 1'b1;
    step();
    checks++;
    if (up_wen !== 1'b1 || up_index !== 12'h000 || ghr_shift !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_sweep0: wen=%b idx=%h ghr=%b, required 1 000 0", up_wen, up_index, ghr_shift);
    end
  endtask

  task automatic test_drop_saturate();
    // 304 updates during the sweep: 4 stored, 300 dropped, counter stops at 255.
    for (int k = 0; k < 304; k++) begin
      set_upd(12'h200 + 12'(k), 2'b10, 1'b1);
      step();
    end
    clr_upd();
    step();
    checks++;
    if (drop_count !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d, required 255", drop_count);
    end
    wait_run("sat");
    step();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (up_wen !== 1'b1 || up_index !== 12'h200 + 12'(j) || up_data !== 2'b11 || ghr_dir !== 1'b1) begin
        errors++;
        $display("FAIL sat_drain_%0d: wen=%b idx=%h data=%b dir=%b, required 1 %h 11 1",
                 j, up_wen, up_index, up_data, ghr_dir, 12'h200 + 12'(j));
      end
      step();
    end
    checks++;
    if (up_wen !== 1'b0 || drop_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_tail: wen=%b drop_count=%0d, required 0 and 255", up_wen, drop_count);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_single_updates();
    test_back_to_back();
    test_init_overflow();
    test_flush();
    test_reset_mid_run();
    test_drop_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
